// File: rtl/csr_pkg.sv
// Shared encodings for the SPAM-side CSR blocks: write-initiator FSM states
// and the response error codes that other CSR blocks decode.
package csr_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  // Timer width needed to hold the terminal count itself.
  function automatic int timer_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/csr_timeout_counter.sv
// Saturating cycle counter with synchronous clear; tc flags that the count
// has reached TIMEOUT_CYCLES, where it then holds.
module csr_timeout_counter
  import csr_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic cclk,
  input  logic rst_cclk,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = timer_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count_q;

  assign tc = (count_q == TC_VAL);

  always_ff @(posedge cclk) begin
    if (rst_cclk || clr) begin
      count_q <= '0;
    end else if (en && !tc) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/csr_write_initiator.sv
// Host CSR write front end: issues one strobe per request toward a write-only
// clock-crossing channel and returns one response per request.
module csr_write_initiator
  import csr_pkg::*;
#(
  parameter int NTARGETS       = 4,
  parameter int WIDTH          = 32,
  parameter int ADDR_BITS      = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                 cclk,
  input  logic                 rst_cclk,
  input  logic                 req_valid_cclk,
  output logic                 req_ready_cclk,
  input  logic [ADDR_BITS-1:0] req_addr_cclk,
  input  logic [WIDTH-1:0]     req_data_cclk,
  output logic                 resp_valid_cclk,
  output logic                 resp_err_cclk,
  output logic [NTARGETS-1:0]  wr_strobe_cclk,
  output logic [WIDTH-1:0]     wr_data_cclk,
  input  logic [NTARGETS-1:0]  wr_wait_cclk,
  input  logic [NTARGETS-1:0]  wr_done_strobe_cclk
);

  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic [WIDTH-1:0]     data_q;
  logic                 err_q;
  logic                 err_d;

  logic [NTARGETS-1:0]  sel;
  logic                 accept;
  logic                 wait_sel;
  logic                 done_sel;
  logic                 issue_fire;
  logic                 tmr_en;
  logic                 tmr_tc;

  function automatic logic addr_mapped(input logic [ADDR_BITS-1:0] a);
    return int'(a) < NTARGETS;
  endfunction

  // Channel select decoded from the latched address; unmapped codes select nothing.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NTARGETS; i++) begin
      sel[i] = (addr_q == ADDR_BITS'(i));
    end
  end

  assign wait_sel = |(wr_wait_cclk & sel);
  assign done_sel = |(wr_done_strobe_cclk & sel);

  assign req_ready_cclk = (state_q == ST_IDLE) && !rst_cclk;
  assign accept         = req_valid_cclk && req_ready_cclk;

  // A timed-out transaction must never strobe, even if the channel frees up.
  assign issue_fire     = (state_q == ST_ISSUE) && !wait_sel && !tmr_tc;
  assign wr_strobe_cclk = issue_fire ? sel : '0;
  assign wr_data_cclk   = data_q;

  assign resp_valid_cclk = (state_q == ST_RESP);
  assign resp_err_cclk   = resp_valid_cclk && (err_q == RESP_ERR);

  assign tmr_en = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

  csr_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .cclk    (cclk),
    .rst_cclk(rst_cclk),
    .clr     (accept),
    .en      (tmr_en),
    .tc      (tmr_tc)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (addr_mapped(req_addr_cclk)) begin
            state_d = ST_ISSUE;
            err_d   = RESP_OK;
          end else begin
            state_d = ST_RESP;
            err_d   = RESP_ERR;
          end
        end
      end
      ST_ISSUE: begin
        if (tmr_tc) begin
          state_d = ST_RESP;
          err_d   = RESP_ERR;
        end else if (!wait_sel) begin
          state_d = ST_WAIT;
        end
      end
      // Completion takes priority over a timeout in the same cycle.
      ST_WAIT: begin
        if (done_sel) begin
          state_d = ST_RESP;
          err_d   = RESP_OK;
        end else if (tmr_tc) begin
          state_d = ST_RESP;
          err_d   = RESP_ERR;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cclk) begin
    if (rst_cclk) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= RESP_OK;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q <= req_addr_cclk;
        data_q <= req_data_cclk;
      end
    end
  end

  a_strobe_onehot : assert property (@(posedge cclk) disable iff (rst_cclk)
    $onehot0(wr_strobe_cclk));
  a_strobe_in_issue : assert property (@(posedge cclk) disable iff (rst_cclk)
    (wr_strobe_cclk != '0) |-> (state_q == ST_ISSUE));

endmodule

// File: tb/tb_csr_write_initiator.sv
// Directed bench for csr_write_initiator: a 4-channel instance for the main
// scenarios and a 3-channel instance for the unmapped-address case.
module tb_csr_write_initiator;

  localparam int W  = 32;
  localparam int AB = 2;
  localparam int TO = 16;

  logic cclk = 1'b0;
  always #5 cclk = ~cclk;

  logic          rst;
  logic          req_valid, req_ready, resp_valid, resp_err;
  logic [AB-1:0] req_addr;
  logic [W-1:0]  req_data, wr_data;
  logic [3:0]    wr_strobe, wr_wait, wr_done;

  logic          req_valid3, req_ready3, resp_valid3, resp_err3;
  logic [AB-1:0] req_addr3;
  logic [W-1:0]  req_data3, wr_data3;
  logic [2:0]    wr_strobe3, wr_wait3, wr_done3;

  int checks = 0;
  int errors = 0;

  csr_write_initiator #(
    .NTARGETS(4), .WIDTH(W), .ADDR_BITS(AB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .cclk(cclk), .rst_cclk(rst),
    .req_valid_cclk(req_valid), .req_ready_cclk(req_ready),
    .req_addr_cclk(req_addr), .req_data_cclk(req_data),
    .resp_valid_cclk(resp_valid), .resp_err_cclk(resp_err),
    .wr_strobe_cclk(wr_strobe), .wr_data_cclk(wr_data),
    .wr_wait_cclk(wr_wait), .wr_done_strobe_cclk(wr_done)
  );

  csr_write_initiator #(
    .NTARGETS(3), .WIDTH(W), .ADDR_BITS(AB), .TIMEOUT_CYCLES(TO)
  ) dut3 (
    .cclk(cclk), .rst_cclk(rst),
    .req_valid_cclk(req_valid3), .req_ready_cclk(req_ready3),
    .req_addr_cclk(req_addr3), .req_data_cclk(req_data3),
    .resp_valid_cclk(resp_valid3), .resp_err_cclk(resp_err3),
    .wr_strobe_cclk(wr_strobe3), .wr_data_cclk(wr_data3),
    .wr_wait_cclk(wr_wait3), .wr_done_strobe_cclk(wr_done3)
  );

  task automatic tick;
    @(posedge cclk);
    #1;
  endtask

  // Present a request while idle and take it on the next edge; returns in the ISSUE cycle.
  task automatic accept_write(input logic [AB-1:0] a, input logic [W-1:0] d);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    tick();
    req_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick(); tick();
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", req_ready); end
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp got %b/%b want 0/0", resp_valid, resp_err); end
    checks++; if (wr_strobe !== 4'b0000) begin errors++; $display("FAIL rst_strobe got %b want 0000", wr_strobe); end
    checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 00000000", wr_data); end
    checks++; if (req_ready3 !== 1'b0) begin errors++; $display("FAIL rst_ready3 got %b want 0", req_ready3); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1 || req_ready3 !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b/%b want 1/1", req_ready, req_ready3); end
  endtask

  task automatic test_write_ch2;
    accept_write(2'd2, 32'hDEADBEEF);
    checks++; if (wr_strobe !== 4'b0100) begin errors++; $display("FAIL ch2_strobe got %b want 0100", wr_strobe); end
    checks++; if (wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL ch2_data got %h want deadbeef", wr_data); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ch2_ready_busy got %b want 0", req_ready); end
    tick();
    checks++; if (wr_strobe !== 4'b0000) begin errors++; $display("FAIL ch2_strobe_once got %b want 0000", wr_strobe); end
    tick(); tick(); tick(); tick();
    wr_done[2] = 1'b1;
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL ch2_resp_early got %b want 0", resp_valid); end
    tick();
    wr_done[2] = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL ch2_resp got %b/%b want 1/0", resp_valid, resp_err); end
    checks++; if (req_ready !== 1'b0 || wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL ch2_resp_hold got %b/%h want 0/deadbeef", req_ready, wr_data); end
    tick();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL ch2_idle got %b/%b want 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_unmapped;
    req_valid3 = 1'b1;
    req_addr3  = 2'd3;
    req_data3  = 32'h12345678;
    tick();
    req_valid3 = 1'b0;
    #1;
    checks++; if (resp_valid3 !== 1'b1 || resp_err3 !== 1'b1) begin errors++; $display("FAIL unmapped_resp got %b/%b want 1/1", resp_valid3, resp_err3); end
    checks++; if (wr_strobe3 !== 3'b000) begin errors++; $display("FAIL unmapped_strobe got %b want 000", wr_strobe3); end
    checks++; if (wr_data3 !== 32'h12345678) begin errors++; $display("FAIL unmapped_data got %h want 12345678", wr_data3); end
    tick();
    checks++; if (resp_valid3 !== 1'b0 || req_ready3 !== 1'b1 || wr_strobe3 !== 3'b000) begin errors++; $display("FAIL unmapped_idle got %b/%b/%b want 0/1/000", resp_valid3, req_ready3, wr_strobe3); end
  endtask

  task automatic test_timeout_stall;
    int early;
    int stall;
    accept_write(2'd1, 32'hA5A50001);
    checks++; if (wr_strobe !== 4'b0010) begin errors++; $display("FAIL to_strobe got %b want 0010", wr_strobe); end
    wr_wait[1] = 1'b1;
    early = 0;
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (resp_valid !== 1'b0 || wr_strobe !== 4'b0000) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL to_early got %0d bad cycles want 0", early); end
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin errors++; $display("FAIL to_resp got %b/%b want 1/1", resp_valid, resp_err); end
    tick();
    accept_write(2'd1, 32'h0BADF00D);
    stall = 0;
    for (int k = 0; k < 4; k++) begin
      if (wr_strobe !== 4'b0000 || resp_valid !== 1'b0 || req_ready !== 1'b0) stall++;
      tick();
    end
    checks++; if (stall != 0) begin errors++; $display("FAIL stall_issue got %0d bad cycles want 0", stall); end
    wr_wait[1] = 1'b0;
    #1;
    checks++; if (wr_strobe !== 4'b0010 || wr_data !== 32'h0BADF00D) begin errors++; $display("FAIL stall_release got %b/%h want 0010/0badf00d", wr_strobe, wr_data); end
    tick();
    wr_done[1] = 1'b1;
    tick();
    wr_done[1] = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL stall_resp got %b/%b want 1/0", resp_valid, resp_err); end
    tick();
  endtask

  task automatic test_ignore_other_done;
    accept_write(2'd3, 32'h33333333);
    checks++; if (wr_strobe !== 4'b1000) begin errors++; $display("FAIL ch3_strobe got %b want 1000", wr_strobe); end
    tick();
    wr_done[0] = 1'b1;
    tick();
    wr_done[0] = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL ch3_other_done got %b want 0", resp_valid); end
    tick();
    wr_done[3] = 1'b1;
    tick();
    wr_done[3] = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL ch3_resp got %b/%b want 1/0", resp_valid, resp_err); end
    tick();
  endtask

  task automatic test_done_at_timeout;
    int early;
    accept_write(2'd2, 32'h22222222);
    checks++; if (wr_strobe !== 4'b0100) begin errors++; $display("FAIL tie_strobe got %b want 0100", wr_strobe); end
    early = 0;
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (resp_valid !== 1'b0) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL tie_early got %0d bad cycles want 0", early); end
    wr_done[2] = 1'b1;
    tick();
    wr_done[2] = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL tie_resp got %b/%b want 1/0", resp_valid, resp_err); end
    tick();
  endtask

  task automatic test_reset_mid_wait;
    accept_write(2'd0, 32'h000000C0);
    checks++; if (wr_strobe !== 4'b0001) begin errors++; $display("FAIL mid_strobe got %b want 0001", wr_strobe); end
    tick();
    rst = 1'b1;
    wr_done[0] = 1'b1;
    tick();
    wr_done[0] = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b0 || wr_strobe !== 4'b0000 || req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst got %b/%b/%b want 0/0000/0", resp_valid, wr_strobe, req_ready); end
    checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL mid_rst_data got %h want 00000000", wr_data); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", req_ready); end
    tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_resp got %b want 0", resp_valid); end
    accept_write(2'd0, 32'h0000C0DE);
    checks++; if (wr_strobe !== 4'b0001) begin errors++; $display("FAIL post_strobe got %b want 0001", wr_strobe); end
    tick();
    wr_done[0] = 1'b1;
    tick();
    wr_done[0] = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || wr_data !== 32'h0000C0DE) begin errors++; $display("FAIL post_resp got %b/%b/%h want 1/0/0000c0de", resp_valid, resp_err, wr_data); end
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    wr_wait    = '0;
    wr_done    = '0;
    req_valid3 = 1'b0;
    req_addr3  = '0;
    req_data3  = '0;
    wr_wait3   = '0;
    wr_done3   = '0;
    test_reset();
    test_write_ch2();
    test_unmapped();
    test_timeout_stall();
    test_ignore_other_done();
    test_done_at_timeout();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/csr_write_initiator.md
# csr_write_initiator

Single-clock front end in the SPAM (cclk) domain that turns host CSR write requests into one-cycle write strobes toward NTARGETS clock-crossing write-only CSR channels. It waits for each channel's completion pulse, then returns one response per request. Requests to unmapped or unresponsive channels complete with an error. Only one write is in flight at a time.

## Interface
Parameters:
- NTARGETS, 4, number of CSR write channels driven
- WIDTH, 32, CSR data width
- ADDR_BITS, 2, width of channel select; must satisfy 2^ADDR_BITS >= NTARGETS
- TIMEOUT_CYCLES, 1023, cclk cycles allowed from issue to completion before an error response

Ports:
- cclk  in  1  clock; all logic is on its rising edge
- rst_cclk  in  1  synchronous, active-high reset
- req_valid_cclk  in  1  host write request valid
- req_ready_cclk  out  1  initiator can accept a request
- req_addr_cclk  in  ADDR_BITS  channel select
- req_data_cclk  in  WIDTH  write data
- resp_valid_cclk  out  1  one-cycle completion pulse
- resp_err_cclk  out  1  qualifies resp_valid_cclk: 1 = unmapped channel or timeout
- wr_strobe_cclk  out  NTARGETS  one-hot, single-cycle write strobe per channel
- wr_data_cclk  out  WIDTH  write data shared by all channels
- wr_wait_cclk  in  NTARGETS  per-channel busy; high while a channel's previous write has not been taken by its target domain
- wr_done_strobe_cclk  in  NTARGETS  per-channel one-cycle completion pulse

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready_cclk=1.
  - On req_valid&&req_ready, latch addr and data, clear the timer.
  - If addr>=NTARGETS, go to RESP with err=1 and issue no strobe.
  - Otherwise go to ISSUE.
- ISSUE:
  - If wr_wait_cclk[addr]==0, drive wr_strobe_cclk[addr]=1 for this cycle and go to WAIT.
  - Otherwise hold in ISSUE with the strobe low. The channel is still busy from an earlier timed-out write.
- WAIT:
  - On wr_done_strobe_cclk[addr], go to RESP with err=0.
  - Done pulses from other channels are ignored.
- Timer:
  - Increments every cycle in ISSUE and WAIT.
  - When the timer equals TIMEOUT_CYCLES and no done pulse arrives that cycle, go to RESP with err=1 and never strobe later.
  - If done and timeout coincide, done wins (err=0).
- RESP: resp_valid_cclk=1 with the latched error for exactly one cycle, then go to IDLE.
- wr_data_cclk always equals the latched data register. It is stable from ISSUE through RESP and until the next accept.
- wr_strobe_cclk is never asserted outside ISSUE. At most one bit is set.
- Timer width is $clog2(TIMEOUT_CYCLES+1) and saturates; it cannot wrap.

## Timing
- Reset values:
  - State IDLE; latched addr/data 0; timer 0; err 0.
  - req_ready_cclk=0 while rst_cclk is high, 1 from the first cycle after reset deasserts.
  - resp_valid_cclk=0, resp_err_cclk=0, wr_strobe_cclk=0, wr_data_cclk=0.
- Normal write, request accepted at edge T:
  - Strobe is high in cycle T+1 if the channel is idle.
  - A done pulse in cycle D gives resp_valid in cycle D+1.
  - req_ready returns in D+2.
- Unmapped write accepted at edge T: resp_valid with err=1 in cycle T+1, no strobe.
- Throughput: at most one request per RESP→IDLE round trip. req_ready is low in ISSUE, WAIT and RESP.
- Reset mid-operation: the transaction is abandoned and no response is produced. Strobe and resp are low from the cycle after rst_cclk is sampled high.
- Strobe and resp outputs are decoded from registered state plus latched address. The ISSUE strobe also depends combinationally on wr_wait_cclk[addr].

## Structure
- State encodings and response error codes go in the shared package csr_pkg as localparams. Other SPAM-side CSR blocks decode the same codes.
- One sub-module: csr_timeout_counter (clear, enable, saturating count, terminal-count flag at TIMEOUT_CYCLES).
- Address decode and the one-hot strobe stay inline.

## Test plan
- Write 0xDEADBEEF to channel 2; model returns done 5 cycles after strobe -> strobe = 4'b0100 for one cycle, wr_data=0xDEADBEEF, resp_valid with err=0 exactly one cycle after done.
- NTARGETS=3, write to addr 3 -> no strobe on any bit, resp_valid/err=1 one cycle after accept.
- TIMEOUT_CYCLES=16, channel 1 never pulses done -> resp err=1 after 16 cycles in ISSUE/WAIT. A following write to channel 1 with wr_wait[1] still high stalls in ISSUE with no strobe; releasing wait lets the strobe fire.
- Done on channel 0 while waiting on channel 3 -> ignored, no response until the channel 3 done arrives.
- Done coinciding with the timer reaching TIMEOUT_CYCLES -> err=0.
- rst_cclk pulsed during WAIT -> no resp_valid; req_ready high the cycle after reset drops; next write completes normally.
